// File: rtl/best_hand_sequencer.sv
// Purpose : walks the 21 five-card subsets of a 7-card hand through an external
//           hand_eval_5card and keeps the best type/rank/subset index.
// Latency : one subset issued per cycle; done pulses 22+EVAL_LATENCY cycles after start acceptance.
// Backpr. : none downstream; start is ignored while busy, and a held start is taken on the first idle cycle.
//
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   start, cards7[7]              run request and the 7 cards, latched on acceptance
//   eval_cards[5]                 5-card hand presented to the evaluator
//   eval_type, eval_rank          evaluator results, EVAL_LATENCY cycles after eval_cards
//   busy, done                    run in progress / one-cycle final-result pulse
//   best_type, best_rank, best_idx  best hand found so far (final when done=1)

package best_hand_pkg;
    typedef struct packed {
        logic [3:0] rank;   // 2..14, ace high
        logic [1:0] suit;
    } card_t;

    typedef enum logic [3:0] {
        high_card      = 4'd0,
        one_pair       = 4'd1,
        two_pair       = 4'd2,
        three_oak      = 4'd3,
        straight       = 4'd4,
        flush          = 4'd5,
        full_house     = 4'd6,
        four_oak       = 4'd7,
        straight_flush = 4'd8
    } hand_type_t;
endpackage

module best_hand_sequencer
    import best_hand_pkg::*;
#(
    parameter int EVAL_LATENCY = 2      // 1..4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  card_t       cards7 [7],
    output card_t       eval_cards [5],
    input  hand_type_t  eval_type,
    input  logic [15:0] eval_rank,
    output logic        busy,
    output logic        done,
    output hand_type_t  best_type,
    output logic [15:0] best_rank,
    output logic [4:0]  best_idx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0] LAST_K     = 5'd20;
    localparam logic [2:0] DRAIN_LAST = 3'(EVAL_LATENCY - 1);

    state_t      state_q, state_d;
    card_t       cards_q [7];
    logic [2:0]  omit_i, omit_j;        // pair of card slots left out of the current subset
    logic [4:0]  issue_k;               // index of the subset currently on eval_cards
    logic [2:0]  drain_cnt;
    logic [EVAL_LATENCY-1:0] pipe_vld;
    logic [4:0]  pipe_idx [EVAL_LATENCY];
    logic [2:0]  keep_idx [5];
    logic        accept;
    logic        take_result;

    assign accept = (state_q == IDLE) && start;

    // The first subset of every run is k=0, so a valid result tagged k=0 is
    // always the first of its run and is taken regardless of its rank.
    assign take_result = pipe_vld[EVAL_LATENCY-1] &&
                         ((pipe_idx[EVAL_LATENCY-1] == 5'd0) || (eval_rank > best_rank));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_k == LAST_K) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Subset walk, in-flight tracking and best-hand register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                cards_q[i] <= '0;
            end
            omit_i    <= 3'd0;
            omit_j    <= 3'd1;
            issue_k   <= 5'd0;
            drain_cnt <= 3'd0;
            pipe_vld  <= '0;
            for (int i = 0; i < EVAL_LATENCY; i++) begin
                pipe_idx[i] <= 5'd0;
            end
            best_type <= high_card;
            best_rank <= 16'd0;
            best_idx  <= 5'd0;
        end else begin
            // Subset counter: (i,j) walks j fastest; it parks on (5,6) after
            // the last issue so eval_cards keeps showing the k=20 hand.
            if (accept) begin
                cards_q <= cards7;
                omit_i  <= 3'd0;
                omit_j  <= 3'd1;
                issue_k <= 5'd0;
            end else if ((state_q == ISSUE) && (issue_k != LAST_K)) begin
                issue_k <= issue_k + 5'd1;
                if (omit_j == 3'd6) begin
                    omit_i <= omit_i + 3'd1;
                    omit_j <= omit_i + 3'd2;
                end else begin
                    omit_j <= omit_j + 3'd1;
                end
            end

            if (state_q == DRAIN) begin
                drain_cnt <= drain_cnt + 3'd1;
            end else begin
                drain_cnt <= 3'd0;
            end

            // Tag each issue so its result is recognised EVAL_LATENCY cycles later.
            pipe_vld[0] <= (state_q == ISSUE);
            pipe_idx[0] <= issue_k;
            for (int i = 1; i < EVAL_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_idx[i] <= pipe_idx[i-1];
            end

            if (accept) begin
                best_type <= high_card;
                best_rank <= 16'd0;
                best_idx  <= 5'd0;
            end else if (take_result) begin
                best_type <= eval_type;
                best_rank <= eval_rank;
                best_idx  <= pipe_idx[EVAL_LATENCY-1];
            end
        end
    end

    // Kept slots in ascending order: skip past omit_i, then past omit_j.
    always_comb begin
        for (int m = 0; m < 5; m++) begin
            keep_idx[m] = 3'(m);
            if (keep_idx[m] >= omit_i) begin
                keep_idx[m] = keep_idx[m] + 3'd1;
            end
            if (keep_idx[m] >= omit_j) begin
                keep_idx[m] = keep_idx[m] + 3'd1;
            end
            eval_cards[m] = cards_q[keep_idx[m]];
        end
    end

endmodule

// File: tb/tb_best_hand_sequencer.sv
`timescale 1ns/1ps
module tb_best_hand_sequencer;
    import best_hand_pkg::*;

    localparam int L       = 2;
    localparam int RUN_CYC = 22 + L;

    typedef struct packed {
        hand_type_t  t;
        logic [15:0] r;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    card_t       cards7 [7];
    card_t       eval_cards [5];
    hand_type_t  eval_type;
    logic [15:0] eval_rank;
    logic        busy, done;
    hand_type_t  best_type;
    logic [15:0] best_rank;
    logic [4:0]  best_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    best_hand_sequencer #(.EVAL_LATENCY(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cards7     (cards7),
        .eval_cards (eval_cards),
        .eval_type  (eval_type),
        .eval_rank  (eval_rank),
        .busy       (busy),
        .done       (done),
        .best_type  (best_type),
        .best_rank  (best_rank),
        .best_idx   (best_idx)
    );

    // ---------------- evaluator model: poker rules, fixed latency ----------------
    function automatic card_t mk(input int r, input int s);
        card_t c;
        c.rank = 4'(r);
        c.suit = 2'(s);
        return c;
    endfunction

    function automatic res_t eval5(input card_t h [5]);
        int cnt [16];
        int distinct, hi, lo, n4, n3, n2, top, score;
        logic fl, str;
        int ord [$];
        hand_type_t t;
        res_t res;
        for (int r = 0; r < 16; r++) cnt[r] = 0;
        fl = 1'b1;
        for (int m = 0; m < 5; m++) begin
            cnt[h[m].rank]++;
            if (h[m].suit != h[0].suit) fl = 1'b0;
        end
        distinct = 0; hi = 0; lo = 15; n4 = 0; n3 = 0; n2 = 0;
        for (int r = 2; r <= 14; r++) begin
            if (cnt[r] > 0) begin
                distinct++;
                if (r > hi) hi = r;
                if (r < lo) lo = r;
            end
            if (cnt[r] >= 4) n4++;
            if (cnt[r] == 3) n3++;
            if (cnt[r] == 2) n2++;
        end
        str = (distinct == 5) && ((hi - lo == 4) ||
              (cnt[14] > 0 && cnt[2] > 0 && cnt[3] > 0 && cnt[4] > 0 && cnt[5] > 0));
        top = (hi - lo == 4) ? hi : 5;
        if (str && fl)              t = straight_flush;
        else if (n4 > 0)            t = four_oak;
        else if (n3 > 0 && n2 > 0)  t = full_house;
        else if (fl)                t = flush;
        else if (str)               t = straight;
        else if (n3 > 0)            t = three_oak;
        else if (n2 > 1)            t = two_pair;
        else if (n2 > 0)            t = one_pair;
        else                        t = high_card;
        if (str) begin
            score = top - 2;
        end else begin
            for (int c = 5; c >= 1; c--)
                for (int r = 14; r >= 2; r--)
                    if (cnt[r] == c) ord.push_back(r);
            while (ord.size() < 3) ord.push_back(2);
            score = (ord[0] - 2) * 169 + (ord[1] - 2) * 13 + (ord[2] - 2);
        end
        res.t = t;
        res.r = 16'(int'(t) * 4096 + score);
        return res;
    endfunction

    res_t epipe [L];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < L; i++) epipe[i] <= '0;
        end else begin
            epipe[0] <= eval5(eval_cards);
            for (int i = 1; i < L; i++) epipe[i] <= epipe[i-1];
        end
    end
    assign eval_type = epipe[L-1].t;
    assign eval_rank = epipe[L-1].r;

    // ---------------- reference: enumerate subsets, keep strict best ----------------
    task automatic get_combo(input card_t c [7], input int k, output card_t h [5]);
        int n = 0;
        int kk = 0;
        for (int m = 0; m < 5; m++) h[m] = '0;
        for (int i = 0; i < 6; i++)
            for (int j = i + 1; j < 7; j++) begin
                if (kk == k)
                    for (int p = 0; p < 7; p++)
                        if (p != i && p != j) begin
                            h[n] = c[p];
                            n++;
                        end
                kk++;
            end
    endtask

    task automatic model_best(input card_t c [7], output hand_type_t bt,
                              output logic [15:0] br, output logic [4:0] bi);
        card_t h [5];
        res_t  e;
        bt = high_card; br = 16'd0; bi = 5'd0;
        for (int k = 0; k < 21; k++) begin
            get_combo(c, k, h);
            e = eval5(h);
            if (k == 0 || e.r > br) begin
                bt = e.t; br = e.r; bi = 5'(k);
            end
        end
    endtask

    function automatic logic [29:0] pack5(input card_t h [5]);
        return {h[4], h[3], h[2], h[1], h[0]};
    endfunction

    task automatic rand_cards(output card_t c [7]);
        int n = 0;
        logic used;
        card_t x;
        while (n < 7) begin
            x = mk($urandom_range(14, 2), $urandom_range(3, 0));
            used = 1'b0;
            for (int p = 0; p < n; p++) if (c[p] == x) used = 1'b1;
            if (!used) begin
                c[n] = x;
                n++;
            end
        end
    endtask

    // Launch one run (cycle 0 = acceptance cycle) and observe ncyc further cycles.
    task automatic run_watch(input card_t c [7], input int ncyc, input int disturb_at,
                             output int first_done, output int ndone, output int busy_bad);
        card_t alt [7];
        @(negedge clk);
        cards7 = c;
        start  = 1'b1;
        first_done = -1; ndone = 0; busy_bad = 0;
        for (int cy = 1; cy <= ncyc; cy++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = cy;
            end
            if (cy <= RUN_CYC && busy !== 1'b1) busy_bad++;
            if (cy > RUN_CYC && busy !== 1'b0) busy_bad++;
            if (cy == disturb_at) begin
                rand_cards(alt);
                cards7 = alt;
                start  = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (best_type !== high_card) begin errors++; $display("FAIL reset_best_type: got %0d expected 0", best_type); end
        checks++; if (best_rank !== 16'd0) begin errors++; $display("FAIL reset_best_rank: got %0d expected 0", best_rank); end
        checks++; if (best_idx !== 5'd0) begin errors++; $display("FAIL reset_best_idx: got %0d expected 0", best_idx); end
        checks++; if (pack5(eval_cards) !== 30'd0) begin errors++; $display("FAIL reset_eval_cards: got %h expected 0", pack5(eval_cards)); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed(input string name, input card_t c [7],
                                 input hand_type_t want_t, input int want_i, input int disturb_at);
        int fd, nd, bb;
        hand_type_t mt; logic [15:0] mr; logic [4:0] mi;
        model_best(c, mt, mr, mi);
        run_watch(c, RUN_CYC + 3, disturb_at, fd, nd, bb);
        checks++; if (fd !== RUN_CYC) begin errors++; $display("FAIL %s done_cycle: got %0d expected %0d", name, fd, RUN_CYC); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL %s done_count: got %0d expected 1", name, nd); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL %s busy_profile: got %0d bad cycles expected 0", name, bb); end
        checks++; if (best_type !== want_t) begin errors++; $display("FAIL %s best_type: got %0d expected %0d", name, best_type, want_t); end
        checks++; if (best_idx !== 5'(want_i)) begin errors++; $display("FAIL %s best_idx: got %0d expected %0d", name, best_idx, want_i); end
        checks++; if (best_rank !== mr) begin errors++; $display("FAIL %s best_rank: got %0d expected %0d", name, best_rank, mr); end
    endtask

    task automatic test_issue_order();
        card_t c [7];
        card_t h [5];
        rand_cards(c);
        @(negedge clk);
        cards7 = c;
        start  = 1'b1;
        for (int cy = 1; cy <= RUN_CYC + 2; cy++) begin
            @(negedge clk);
            start = 1'b0;
            if (cy <= 21) begin
                get_combo(c, cy - 1, h);
                checks++;
                if (pack5(eval_cards) !== pack5(h)) begin
                    errors++;
                    $display("FAIL issue_order k=%0d: got %h expected %h", cy - 1, pack5(eval_cards), pack5(h));
                end
            end
        end
        get_combo(c, 20, h);
        checks++; if (pack5(eval_cards) !== pack5(h)) begin errors++; $display("FAIL idle_hold_k20: got %h expected %h", pack5(eval_cards), pack5(h)); end
    endtask

    task automatic test_reset_mid_run();
        card_t c [7];
        int nd, fd, bb;
        hand_type_t mt; logic [15:0] mr; logic [4:0] mi;
        rand_cards(c);
        @(negedge clk);
        cards7 = c;
        start  = 1'b1;
        nd = 0;
        for (int cy = 1; cy <= 10; cy++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) nd++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b expected 0", busy); end
        checks++; if ({best_type, best_rank, best_idx} !== 25'd0) begin errors++; $display("FAIL midreset_best: got %h expected 0", {best_type, best_rank, best_idx}); end
        for (int cy = 0; cy < 30; cy++) begin
            @(negedge clk);
            if (done) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", nd); end
        rand_cards(c);
        model_best(c, mt, mr, mi);
        run_watch(c, RUN_CYC + 2, -1, fd, nd, bb);
        checks++; if (fd !== RUN_CYC) begin errors++; $display("FAIL midreset_rerun_done: got %0d expected %0d", fd, RUN_CYC); end
        checks++; if ({best_type, best_rank, best_idx} !== {mt, mr, mi}) begin
            errors++; $display("FAIL midreset_rerun_best: got %h expected %h", {best_type, best_rank, best_idx}, {mt, mr, mi});
        end
    endtask

    task automatic test_start_held();
        card_t c [3][7];
        int run;
        hand_type_t mt; logic [15:0] mr; logic [4:0] mi;
        for (int r = 0; r < 3; r++) rand_cards(c[r]);
        run = 0;
        @(negedge clk);
        cards7 = c[0];
        start  = 1'b1;
        for (int cy = 1; cy <= 3 * (RUN_CYC + 1) + 5; cy++) begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (cy !== RUN_CYC + run * (RUN_CYC + 1)) begin
                    errors++; $display("FAIL held_done_cycle run%0d: got %0d expected %0d", run, cy, RUN_CYC + run * (RUN_CYC + 1));
                end
                if (run < 3) begin
                    model_best(c[run], mt, mr, mi);
                    checks++;
                    if ({best_type, best_rank, best_idx} !== {mt, mr, mi}) begin
                        errors++; $display("FAIL held_best run%0d: got %h expected %h", run, {best_type, best_rank, best_idx}, {mt, mr, mi});
                    end
                end
                run++;
                if (run < 3) cards7 = c[run];
                else start = 1'b0;
            end
        end
        start = 1'b0;
        checks++; if (run !== 3) begin errors++; $display("FAIL held_done_count: got %0d expected 3", run); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        card_t c [7];
        int fd, nd, bb;
        hand_type_t mt; logic [15:0] mr; logic [4:0] mi;
        for (int n = 0; n < 6; n++) begin
            rand_cards(c);
            model_best(c, mt, mr, mi);
            run_watch(c, RUN_CYC + 2, -1, fd, nd, bb);
            checks++; if (fd !== RUN_CYC || nd !== 1) begin errors++; $display("FAIL rand%0d done: got cycle %0d count %0d expected %0d/1", n, fd, nd, RUN_CYC); end
            checks++; if (best_type !== mt) begin errors++; $display("FAIL rand%0d best_type: got %0d expected %0d", n, best_type, mt); end
            checks++; if (best_rank !== mr) begin errors++; $display("FAIL rand%0d best_rank: got %0d expected %0d", n, best_rank, mr); end
            checks++; if (best_idx !== mi) begin errors++; $display("FAIL rand%0d best_idx: got %0d expected %0d", n, best_idx, mi); end
        end
    endtask

    initial begin
        card_t royal [7];
        card_t strt [7];
        card_t quads [7];
        card_t low [5];
        res_t  low_res;

        for (int p = 0; p < 7; p++) cards7[p] = '0;
        royal = '{mk(14,3), mk(13,3), mk(12,3), mk(11,3), mk(10,3), mk(2,2), mk(3,1)};
        strt  = '{mk(2,0), mk(3,1), mk(4,2), mk(5,3), mk(6,0), mk(7,1), mk(8,2)};
        quads = '{mk(6,2), mk(6,1), mk(6,0), mk(6,3), mk(2,2), mk(2,1), mk(2,0)};
        low   = '{mk(2,0), mk(3,1), mk(4,2), mk(5,3), mk(6,0)};

        test_reset();
        test_directed("royal_flush", royal, straight_flush, 20, -1);
        test_directed("straight", strt, straight, 0, -1);
        low_res = eval5(low);
        checks++; if (!(best_rank > low_res.r)) begin errors++; $display("FAIL straight_beats_low: got %0d expected above %0d", best_rank, low_res.r); end
        test_directed("tie_break", quads, four_oak, 18, -1);
        test_directed("mid_run_disturb", royal, straight_flush, 20, 8);
        test_issue_order();
        test_reset_mid_run();
        test_start_held();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
